// File: rtl/mole_pkg.sv
// Shared types and constants for the mole reaction-game front end.
package mole_pkg;

  typedef enum logic [0:0] {
    LIT  = 1'b0,
    DARK = 1'b1
  } mole_state_t;

  localparam int PEND_W = 3;
  localparam logic [PEND_W-1:0] PEND_MAX = 3'd7;

  localparam int unsigned DEF_ON_CYCLES       = 32'd200000000;
  localparam int unsigned DEF_OFF_CYCLES      = 32'd250000000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd1000000;

  // Saturating increment of the pending-points accumulator.
  function automatic logic [PEND_W-1:0] pend_add_sat(input logic [PEND_W-1:0] base,
                                                     input logic inc);
    if (inc && (base != PEND_MAX)) begin
      return base + 3'd1;
    end else begin
      return base;
    end
  endfunction

endpackage

// File: rtl/mole_hit_unit_if.sv
// Valid/ack score port between the hit unit and the register-file write injector.
interface mole_hit_unit_if;
  import mole_pkg::*;

  logic [PEND_W-1:0] score_data;
  logic              score_valid;
  logic              score_ack;

  modport master (output score_data, output score_valid, input score_ack);
  modport slave  (input score_data, input score_valid, output score_ack);

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debounce counter.
module btn_debounce
  import mole_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic        sync1_r;
  logic        sync2_r;
  logic        db_r;
  logic [31:0] cnt_r;

  // Synchronize the raw level, then accept it only after it has held steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      db_r    <= 1'b1;
      cnt_r   <= 32'd0;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
      if (sync2_r == db_r) begin
        cnt_r <= 32'd0;
      end else if (cnt_r == DB_LAST) begin
        db_r  <= sync2_r;
        cnt_r <= 32'd0;
      end else begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

  assign dout = db_r;

endmodule

// File: rtl/mole_hit_unit.sv
// Mole game front end: button conditioning, LIT/DARK timing, hit scoring and score port.
// Build option MOLE_DEBOUNCE_EN enables the debouncer; without it the synchronizer feeds the FSM directly.
module mole_hit_unit
  import mole_pkg::*;
#(
  parameter int unsigned ON_CYCLES       = DEF_ON_CYCLES,
  parameter int unsigned OFF_CYCLES      = DEF_OFF_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_n,
  output logic            led_out,
  output logic            hit_pulse,
  output logic            miss_pulse,
  mole_hit_unit_if.master score
);

  localparam logic [31:0] ON_LAST  = 32'(ON_CYCLES - 1);
  localparam logic [31:0] OFF_LAST = 32'(OFF_CYCLES - 1);

  logic              btn_db_s;
  logic              btn_prev_r;
  logic              press_s;
  mole_state_t       state_r;
  mole_state_t       next_state_s;
  logic [31:0]       cnt_r;
  logic [31:0]       cnt_next_s;
  logic              hit_s;
  logic              miss_s;
  logic [PEND_W-1:0] pend_r;
  logic [PEND_W-1:0] pend_base_s;
  logic [PEND_W-1:0] pend_next_s;
  logic              valid_r;
  logic              led_r;
  logic              hit_r;
  logic              miss_r;

`ifdef MOLE_DEBOUNCE_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (btn_n),
    .dout (btn_db_s)
  );
`else
  logic sync1_r;
  logic sync2_r;
  logic unused_debounce_s;

  // Bare synchronizer: every bounce edge reaches the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
    end
  end

  assign btn_db_s          = sync2_r;
  assign unused_debounce_s = (DEBOUNCE_CYCLES != 32'd0);
`endif

  assign press_s = btn_prev_r & ~btn_db_s;

  // Next state, phase counter and event strobes; a press beats a same-cycle timeout.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = cnt_r + 32'd1;
    hit_s        = 1'b0;
    miss_s       = 1'b0;
    case (state_r)
      LIT: begin
        if (press_s) begin
          next_state_s = DARK;
          cnt_next_s   = 32'd0;
          hit_s        = 1'b1;
        end else if (cnt_r == ON_LAST) begin
          next_state_s = DARK;
          cnt_next_s   = 32'd0;
          miss_s       = 1'b1;
        end else begin
          next_state_s = LIT;
        end
      end
      DARK: begin
        if (cnt_r == OFF_LAST) begin
          next_state_s = LIT;
          cnt_next_s   = 32'd0;
        end else begin
          next_state_s = DARK;
        end
      end
      default: begin
        next_state_s = LIT;
        cnt_next_s   = 32'd0;
      end
    endcase
  end

  // Pending points: an accepted transfer clears first, then a same-cycle hit adds one.
  always_comb begin
    pend_base_s = pend_r;
    if (score.score_ack && valid_r) begin
      pend_base_s = {PEND_W{1'b0}};
    end else begin
      pend_base_s = pend_r;
    end
    pend_next_s = pend_add_sat(pend_base_s, hit_s);
  end

  // State, counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= LIT;
      cnt_r      <= 32'd0;
      pend_r     <= {PEND_W{1'b0}};
      valid_r    <= 1'b0;
      led_r      <= 1'b1;
      hit_r      <= 1'b0;
      miss_r     <= 1'b0;
      btn_prev_r <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= cnt_next_s;
      pend_r     <= pend_next_s;
      valid_r    <= (pend_next_s != {PEND_W{1'b0}});
      led_r      <= (next_state_s == LIT);
      hit_r      <= hit_s;
      miss_r     <= miss_s;
      btn_prev_r <= btn_db_s;
    end
  end

  assign led_out           = led_r;
  assign hit_pulse         = hit_r;
  assign miss_pulse        = miss_r;
  assign score.score_data  = pend_r;
  assign score.score_valid = valid_r;

endmodule

// File: doc/mole_hit_unit.md
# mole_hit_unit

Front end of the single-mole reaction game. Conditions the raw active-low push button and runs the lit/dark timing of the target LED. Scores a hit when the button is pressed while the LED is lit, and accumulates pending points. Presents those points on a valid/ack port to the register-file write-injection path, which writes them into r30 whenever the processor is not writing.

## Interface
- `ON_CYCLES`, default 200000000: cycles the LED stays lit without a hit.
- `OFF_CYCLES`, default 250000000: cycles the LED stays dark before relighting.
- `DEBOUNCE_CYCLES`, default 1000000: cycles of stable synchronized level required to accept a new button level.
- `clk`, input, 1: single system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `btn_n`, input, 1: raw asynchronous button, low = pressed.
- `led_out`, output, 1: target LED, high = lit.
- `score_data`, output, 3: pending points, 0..7.
- `score_valid`, output, 1: high iff `score_data != 0`.
- `score_ack`, input, 1: consumer wrote `score_data` this cycle. Only meaningful while `score_valid` is high.
- `hit_pulse`, output, 1: one-cycle pulse per scored hit.
- `miss_pulse`, output, 1: one-cycle pulse when the lit window expires unhit.

## Operation
- Input path: `btn_n` passes through a 2-flop synchronizer, then the debouncer, producing `btn_db` with reset value 1 (released).
  - `press` is a one-cycle strobe on a `btn_db` 1→0 transition.
  - Releases generate nothing.
- FSM states:
  - LIT (reset state): `led_out`=1.
  - DARK: `led_out`=0.
- One 32-bit phase counter, cleared on every state change.
- Transitions out of LIT:
  - `press` → DARK, `hit_pulse`=1.
  - Otherwise, counter == `ON_CYCLES`-1 → DARK, `miss_pulse`=1.
- Transitions out of DARK:
  - Counter == `OFF_CYCLES`-1 → LIT.
  - `press` in DARK is ignored.
- Press and timeout in the same LIT cycle: the hit wins. `miss_pulse` stays 0.
- Pending accumulator `pend`, 3 bits, saturating at 7. Each hit adds 1.
  - `score_ack` && `score_valid`: `pend` becomes 0, or 1 if a hit is scored in the same cycle.
  - `score_ack` while `score_valid`=0 has no effect.
  - Saturated at 7: further hits still pulse `hit_pulse` but are not counted.
- `score_data` = `pend`, registered. It holds stable while `score_valid` is high and `score_ack` is low.
- Reset state: LIT, counter 0, `pend` 0, sync flops and `btn_db` = 1, debounce counter 0.
  - Reset mid-window or with points pending discards the window and the pending points.

## Timing
- All outputs are registered. Reset values: `led_out`=1, `score_data`=0, `score_valid`=0, `hit_pulse`=0, `miss_pulse`=0.
- A stable level change on `btn_n` reaches `btn_db` 2 + `DEBOUNCE_CYCLES` cycles later.
- `press` is combinational from the `btn_db` edge. In the cycle after that edge:
  - `led_out` falls.
  - `hit_pulse` is high.
  - `pend` has incremented.
- LIT lasts exactly `ON_CYCLES` cycles and DARK exactly `OFF_CYCLES` cycles, measured from the first cycle in the state.
- Debouncer:
  - Counter resets whenever the synchronized input equals `btn_db`.
  - Otherwise it counts up. At `DEBOUNCE_CYCLES`-1 it loads the new level into `btn_db` and clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` produces no `btn_db` change.
- Handshake: the transfer completes in the cycle where `score_valid` && `score_ack`. The new `pend` is visible the next cycle.

## Configuration
- `MOLE_DEBOUNCE_EN` defined: the debouncer is instantiated as described.
- `MOLE_DEBOUNCE_EN` undefined:
  - `btn_db` is the synchronizer output directly, so the `DEBOUNCE_CYCLES` parameter is unused.
  - Press-to-LED latency is 2 cycles + 1.
  - Every bounce edge that falls in LIT can score. This mode is for simulation only.

## Structure
- Package `mole_pkg`:
  - State typedef `mole_state_t` {LIT, DARK}.
  - `PEND_W`=3 and `PEND_MAX`=7.
  - Default timing constants.
- Sub-module `btn_debounce`: synchronizer plus debounce counter. Parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `din`, `dout`. Instantiated under `MOLE_DEBOUNCE_EN`.
- Top-level `mole_hit_unit` holds the FSM, phase counter and accumulator.

## Test plan
All scenarios use `ON_CYCLES`=10, `OFF_CYCLES`=5, `DEBOUNCE_CYCLES`=4.
- Reset, no press → `led_out` 1 for 10 cycles, `miss_pulse` once, 0 for 5 cycles, then 1 again; `score_valid` stays 0.
- Press held 8 cycles during LIT, `score_ack`=0 → `led_out` falls 7 cycles after `btn_n` falls, `hit_pulse` once, `score_data`=1, `score_valid`=1.
- Press during DARK → no `hit_pulse`, `score_data` unchanged.
- 2-cycle low glitch on `btn_n` in LIT → no hit. With `MOLE_DEBOUNCE_EN` undefined → hit.
- Nine hits without ack → `score_data` saturates at 7, nine `hit_pulse`s. Then `score_ack` for one cycle → `score_data`=0, `score_valid`=0 next cycle.
- `score_ack` in the same cycle a hit is scored, with `score_data`=3 → next cycle `score_data`=1. Reset asserted with `score_data`=5 → next cycle `score_data`=0, `led_out`=1.
